// File: rtl/fan_pwm_pkg.sv
// Shared definitions for the fan PWM controller: default widths, the
// register map seen by the AXI4-Lite slave, and the enable bit position.
package fan_pwm_pkg;

    // Default counter width for period, duty and tach count.
    localparam int FAN_CNT_W       = 16;
    // Default tach measurement window in clock cycles.
    localparam int FAN_GATE_CYCLES = 100000;
    // Default depth of the tach input synchroniser.
    localparam int FAN_SYNC_STAGES = 2;

    // Byte offsets of the slave registers (slv_reg0..3).
    typedef enum logic [3:0] {
        REG_CTRL   = 4'h0,
        REG_PERIOD = 4'h4,
        REG_DUTY   = 4'h8,
        REG_TACH   = 4'hC
    } fan_reg_e;

    // Bit of the control register that enables PWM and tach measurement.
    localparam int CTRL_ENABLE_BIT = 0;

endpackage

// File: rtl/fan_tach_meter.sv
// Tachometer meter: synchronises the asynchronous tach pulse, detects rising
// edges, counts them over a fixed gate window and publishes the count.
//
// tach_valid is a single-cycle strobe with no back-pressure: tach_count
// changes only on the cycle tach_valid is high and is stable until the next
// strobe, so a consumer may sample tach_count at any time.
module fan_tach_meter
    import fan_pwm_pkg::*;
#(
    parameter int CNT_W       = FAN_CNT_W,
    parameter int GATE_CYCLES = FAN_GATE_CYCLES,
    parameter int SYNC_STAGES = FAN_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tach_in,
    output logic [CNT_W-1:0] tach_count,
    output logic             tach_valid,
    output logic             fan_stall
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   tach_sync;
    logic                   tach_rise;
    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       edge_next;
    logic                   gate_last;

    // Shift the raw tach pin through the synchroniser and keep one extra
    // delayed copy for edge detection; runs regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tach_in};
            sync_prev_q <= tach_sync;
        end
    end

    // Rising-edge detect and saturating edge-count increment.
    always_comb begin
        tach_sync = sync_q[SYNC_STAGES-1];
        tach_rise = tach_sync & ~sync_prev_q;
        gate_last = (gate_cnt == GATE_LAST);
        edge_next = edge_cnt;
        if (tach_rise && (edge_cnt != '1)) begin
            edge_next = edge_cnt + CNT_W'(1);
        end
    end

    // Gate window and edge accumulation; both restart from zero on disable
    // and at the end of each window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (!enable) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (gate_last) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_next;
        end
    end

    // Publish the closing window's count (including an edge seen on the
    // terminal cycle) together with the strobe and the stall flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tach_count <= '0;
            tach_valid <= 1'b0;
            fan_stall  <= 1'b0;
        end else if (!enable) begin
            tach_valid <= 1'b0;
            fan_stall  <= 1'b0;
        end else if (gate_last) begin
            tach_count <= edge_next;
            tach_valid <= 1'b1;
            fan_stall  <= (edge_next == '0);
        end else begin
            tach_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fan_pwm_core.sv
// Fan PWM core: shadow-buffered period/duty registers, the period counter,
// the PWM compare and the tachometer meter. New period/duty values take
// effect only on a period boundary (or at once while disabled) so the PWM
// pin never produces a runt pulse.
module fan_pwm_core
    import fan_pwm_pkg::*;
#(
    parameter int CNT_W       = FAN_CNT_W,
    parameter int GATE_CYCLES = FAN_GATE_CYCLES,
    parameter int SYNC_STAGES = FAN_SYNC_STAGES
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             cfg_update,
    input  logic             tach_in,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] tach_count,
    output logic             tach_valid,
    output logic             fan_stall
);

    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] duty_sh;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             load_req;
    logic             period_live;
    logic             at_last;
    logic             shadow_load;

    // Boundary detection and shadow-load decision. A write arriving on the
    // load cycle itself is taken directly, so the pending flag ends clear.
    // With period_sh=0 while enabled there is no boundary: leaving a zero
    // period requires a disable.
    always_comb begin
        load_req    = pending | cfg_update;
        period_live = cfg_enable && (period_sh != '0);
        at_last     = (cnt == (period_sh - CNT_W'(1)));
        shadow_load = load_req && (!cfg_enable || at_last);
    end

    // Shadow registers and the pending-update flag.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            period_sh <= '0;
            duty_sh   <= '0;
            pending   <= 1'b0;
        end else if (shadow_load) begin
            period_sh <= cfg_period;
            duty_sh   <= cfg_duty;
            pending   <= 1'b0;
        end else if (cfg_update) begin
            pending   <= 1'b1;
        end
    end

    // Period counter: 0..period_sh-1 while running, held at 0 otherwise.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt <= '0;
        end else if (!period_live || at_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered PWM compare and period-start strobe; both reflect the
    // counter value of the previous cycle so they stay aligned.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= period_live && (cnt < duty_sh);
            period_start <= period_live && (cnt == '0);
        end
    end

    fan_tach_meter #(
        .CNT_W       (CNT_W),
        .GATE_CYCLES (GATE_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tach (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .enable     (cfg_enable),
        .tach_in    (tach_in),
        .tach_count (tach_count),
        .tach_valid (tach_valid),
        .fan_stall  (fan_stall)
    );

endmodule
